// File: rtl/ktms_perfmon_sched_if.sv
// ktms_perfmon_sched_if: config, perfmon read port and record stream of the snapshot scheduler
interface ktms_perfmon_sched_if #(
    parameter int ways = 10,
    parameter int idx_width = $clog2(ways),
    parameter int seq_width = 16
);
    logic                 cfg_v_i;
    logic                 cfg_en_i;
    logic [31:0]          cfg_interval_i;
    logic [ways-1:0]      cfg_mask_i;
    logic                 trig_i;
    logic                 rd_v_o;
    logic                 rd_r_i;
    logic [idx_width-1:0] rd_idx_o;
    logic                 rsp_v_i;
    logic                 rsp_r_o;
    logic [63:0]          rsp_d_i;
    logic                 rec_v_o;
    logic                 rec_r_i;
    logic [idx_width-1:0] rec_idx_o;
    logic [seq_width-1:0] rec_seq_o;
    logic                 rec_last_o;
    logic [63:0]          rec_d_o;
    logic                 busy_o;
    logic [31:0]          overrun_cnt_o;

    modport slave (
        input  cfg_v_i, cfg_en_i, cfg_interval_i, cfg_mask_i, trig_i,
        input  rd_r_i, rsp_v_i, rsp_d_i, rec_r_i,
        output rd_v_o, rd_idx_o, rsp_r_o, rec_v_o, rec_idx_o, rec_seq_o, rec_last_o, rec_d_o,
        output busy_o, overrun_cnt_o
    );

    modport master (
        output cfg_v_i, cfg_en_i, cfg_interval_i, cfg_mask_i, trig_i,
        output rd_r_i, rsp_v_i, rsp_d_i, rec_r_i,
        input  rd_v_o, rd_idx_o, rsp_r_o, rec_v_o, rec_idx_o, rec_seq_o, rec_last_o, rec_d_o,
        input  busy_o, overrun_cnt_o
    );
endinterface

// File: rtl/ktms_perfmon_sched.sv
// ktms_perfmon_sched: periodic/triggered walker that reads enabled perfmon counters and emits tagged records
module ktms_perfmon_sched #(
    parameter int ways = 10,
    parameter int idx_width = $clog2(ways),
    parameter int seq_width = 16
) (
    input logic                 clk,
    input logic                 reset,
    ktms_perfmon_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP, PUSH} state_t;

    state_t               state_q, state_d;
    logic                 en_q;
    logic [31:0]          interval_q, timer_q, timer_d, overrun_q, overrun_d;
    logic [ways-1:0]      mask_q, snap_q, snap_d, scan, snap_clr;
    logic [idx_width-1:0] idx_q, idx_d, low_idx;
    logic [seq_width-1:0] seq_q, seq_d;
    logic [63:0]          data_q, data_d;
    logic                 last_q, last_d, tick, req;

    assign tick     = en_q && (interval_q != 32'd0) && (timer_q == 32'd1);
    assign req      = tick || bus.trig_i;
    assign snap_clr = snap_q & ~(ways'(1) << idx_q);

    // Timer counts down and reloads so a tick lands every interval cycles after a config load
    always_comb timer_d = bus.cfg_v_i ? bus.cfg_interval_i :
                          (en_q && interval_q != 32'd0) ? (tick ? interval_q : timer_q - 32'd1) : timer_q;

    // Lowest set bit of the live mask when idle, else of the bits still left in this walk
    always_comb begin
        scan = (state_q == IDLE) ? mask_q : snap_q;
        low_idx = '0;
        for (int i = ways - 1; i >= 0; i--)
            if (scan[i]) low_idx = idx_width'(i);
    end

    // Walk FSM: start/drop requests, one outstanding read, record held until accepted
    always_comb begin
        state_d = state_q;
        snap_d = snap_q;
        idx_d = idx_q;
        seq_d = seq_q;
        data_d = data_q;
        last_d = last_q;
        overrun_d = (req && state_q != IDLE && overrun_q != '1) ? overrun_q + 32'd1 : overrun_q;
        case (state_q)
            IDLE: if (req && mask_q != '0) begin
                state_d = ISSUE;
                seq_d = seq_q + 1'b1;
                snap_d = mask_q;
                idx_d = low_idx;
            end
            ISSUE: if (bus.rd_r_i) state_d = RESP;
            RESP: if (bus.rsp_v_i) begin
                state_d = PUSH;
                data_d = bus.rsp_d_i;
                snap_d = snap_clr;
                last_d = (snap_clr == '0);
            end
            PUSH: if (bus.rec_r_i) begin
                state_d = last_q ? IDLE : ISSUE;
                idx_d = low_idx;
            end
        endcase
    end

    // State and configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            en_q <= 1'b0;
            interval_q <= '0;
            mask_q <= '0;
            timer_q <= '0;
            overrun_q <= '0;
            snap_q <= '0;
            idx_q <= '0;
            seq_q <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            overrun_q <= overrun_d;
            snap_q <= snap_d;
            idx_q <= idx_d;
            seq_q <= seq_d;
            data_q <= data_d;
            last_q <= last_d;
            if (bus.cfg_v_i) begin
                en_q <= bus.cfg_en_i;
                interval_q <= bus.cfg_interval_i;
                mask_q <= bus.cfg_mask_i;
            end
        end
    end

    assign bus.rd_v_o        = (state_q == ISSUE);
    assign bus.rsp_r_o       = (state_q == RESP);
    assign bus.rec_v_o       = (state_q == PUSH);
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.rd_idx_o      = idx_q;
    assign bus.rec_idx_o     = idx_q;
    assign bus.rec_seq_o     = seq_q;
    assign bus.rec_last_o    = last_q;
    assign bus.rec_d_o       = data_q;
    assign bus.overrun_cnt_o = overrun_q;
endmodule

// File: tb/tb_ktms_perfmon_sched.sv
// tb_ktms_perfmon_sched: randomized scoreboard bench against a request-level reference model
module tb_ktms_perfmon_sched;
    localparam int WAYS = 10;
    localparam int IW = $clog2(WAYS);
    localparam int SW = 8;

    typedef struct {int idx; int seq; bit last;} rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ktms_perfmon_sched_if #(.ways(WAYS), .seq_width(SW)) bus ();
    ktms_perfmon_sched #(.ways(WAYS), .seq_width(SW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0, passes = 0;
    bit stall = 0, hold = 0;
    bit en_m = 0, busy_m = 0, just_started = 0;
    longint int_m = 0, cfg_cyc = 0, cyc = 0, ovr_m = 0;
    logic [WAYS-1:0] mask_m = '0;
    int seq_m = 0, remaining = 0, outstanding = 0, last_seq = -1;
    rec_t recq[$];
    int rdq[$];
    logic [63:0] dq[$];
    logic [63:0] cur_d = '0;
    bit prev_rd_wait = 0, prev_rec_wait = 0;
    logic [IW-1:0] prev_rd_idx, prev_rec_idx;
    logic [63:0] prev_rec_d;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: request-level view of timer ticks, snapshot acceptance and overruns
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            en_m = 0; int_m = 0; mask_m = '0; seq_m = 0; ovr_m = 0;
            busy_m = 0; remaining = 0; just_started = 0;
            recq.delete(); rdq.delete();
        end else begin
            bit tick;
            int hi;
            chk("busy", bus.busy_o, busy_m);
            if (just_started) begin
                chk("rd_v_rise", bus.rd_v_o, 1);
                just_started = 0;
            end
            tick = en_m && int_m != 0 && cyc > cfg_cyc && ((cyc - cfg_cyc) % int_m) == 0;
            if (tick || bus.trig_i) begin
                if (!busy_m && mask_m != '0) begin
                    seq_m = (seq_m + 1) % (1 << SW);
                    busy_m = 1;
                    just_started = 1;
                    remaining = 0;
                    hi = 0;
                    for (int i = 0; i < WAYS; i++) if (mask_m[i]) hi = i;
                    for (int i = 0; i < WAYS; i++)
                        if (mask_m[i]) begin
                            rdq.push_back(i);
                            recq.push_back('{idx: i, seq: seq_m, last: (i == hi)});
                            remaining++;
                        end
                end else if (busy_m && ovr_m != 64'hFFFF_FFFF) ovr_m++;
            end
            if (bus.rec_v_o && bus.rec_r_i && remaining > 0) begin
                remaining--;
                if (remaining == 0) busy_m = 0;
            end
            if (bus.cfg_v_i) begin
                en_m = bus.cfg_en_i;
                int_m = longint'(bus.cfg_interval_i);
                mask_m = bus.cfg_mask_i;
                cfg_cyc = cyc;
            end
        end
    end

    // Monitor: pops expected reads/records on handshakes and checks hold-stability
    always @(negedge clk) begin
        if (reset) begin
            dq.delete();
            outstanding = 0;
            prev_rd_wait = 0;
            prev_rec_wait = 0;
        end else begin
            if (prev_rd_wait) begin
                chk("rd_v_hold", bus.rd_v_o, 1);
                chk("rd_idx_stable", bus.rd_idx_o, prev_rd_idx);
            end
            if (prev_rec_wait) begin
                chk("rec_v_hold", bus.rec_v_o, 1);
                chk("rec_idx_stable", bus.rec_idx_o, prev_rec_idx);
                chk("rec_d_stable", bus.rec_d_o, prev_rec_d);
            end
            if (bus.rd_v_o && bus.rd_r_i) begin
                chk("rd_expected", rdq.size() > 0, 1);
                if (rdq.size() > 0) chk("rd_idx", bus.rd_idx_o, rdq.pop_front());
                cur_d = {$urandom, $urandom};
                cur_d[63:56] = 8'(bus.rd_idx_o);
                dq.push_back(cur_d);
                outstanding++;
                chk("one_outstanding", outstanding, 1);
            end
            if (bus.rsp_v_i && bus.rsp_r_o) outstanding--;
            if (bus.rec_v_o && bus.rec_r_i) begin
                chk("rec_expected", recq.size() > 0 && dq.size() > 0, 1);
                if (recq.size() > 0 && dq.size() > 0) begin
                    rec_t e;
                    e = recq.pop_front();
                    chk("rec_idx", bus.rec_idx_o, e.idx);
                    chk("rec_seq", bus.rec_seq_o, e.seq);
                    chk("rec_last", bus.rec_last_o, e.last);
                    chk("rec_d", bus.rec_d_o, dq.pop_front());
                end
                last_seq = int'(bus.rec_seq_o);
            end
            prev_rd_wait = bus.rd_v_o && !bus.rd_r_i;
            prev_rd_idx = bus.rd_idx_o;
            prev_rec_wait = bus.rec_v_o && !bus.rec_r_i;
            prev_rec_idx = bus.rec_idx_o;
            prev_rec_d = bus.rec_d_o;
        end
    end

    // Responder and sink: ready/valid either zero-wait or randomly stalled
    always @(posedge clk) begin
        #1;
        bus.rd_r_i = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
        bus.rsp_v_i = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
        bus.rec_r_i = !hold && (stall ? ($urandom_range(0, 2) == 0) : 1'b1);
        bus.rsp_d_i = cur_d;
    end

    task automatic step(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic cfg(bit en, int iv, int m);
        bus.cfg_v_i = 1; bus.cfg_en_i = en; bus.cfg_interval_i = iv; bus.cfg_mask_i = WAYS'(m);
        step();
        bus.cfg_v_i = 0;
    endtask

    task automatic trig();
        bus.trig_i = 1;
        step();
        bus.trig_i = 0;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((bus.busy_o || busy_m) && n < budget) begin step(); n++; end
        chk("idle_in_budget", n < budget, 1);
    endtask

    task automatic chk_zero_outputs(string tag);
        chk({tag, "_rd_v"}, bus.rd_v_o, 0);
        chk({tag, "_rsp_r"}, bus.rsp_r_o, 0);
        chk({tag, "_rec_v"}, bus.rec_v_o, 0);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_overrun"}, bus.overrun_cnt_o, 0);
        chk({tag, "_rec_d"}, bus.rec_d_o, 0);
        chk({tag, "_rec_seq"}, bus.rec_seq_o, 0);
        chk({tag, "_rd_idx"}, bus.rd_idx_o, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        bus.cfg_v_i = 0; bus.cfg_en_i = 0; bus.cfg_interval_i = 0; bus.cfg_mask_i = '0;
        bus.trig_i = 0; bus.rd_r_i = 1; bus.rsp_v_i = 1; bus.rsp_d_i = '0; bus.rec_r_i = 1;
        step(3);
        chk_zero_outputs("reset");
        reset = 0;
        step(2);

        cfg(1, 100, 10'h3FF);
        step(250);
        cfg(0, 0, 10'h3FF);
        wait_idle(200);
        chk("overrun_periodic", bus.overrun_cnt_o, ovr_m);

        cfg(0, 0, 10'h0A5);
        trig();
        wait_idle(100);

        cfg(1, 10, 10'h3FF);
        begin
            int n = 0;
            while (!bus.rec_v_o && n < 100) begin step(); n++; end
            chk("first_rec_in_budget", n < 100, 1);
        end
        hold = 1;
        step(50);
        hold = 0;
        step(3);
        cfg(0, 10, 10'h3FF);
        wait_idle(200);
        chk("overrun_blocked", bus.overrun_cnt_o, ovr_m);

        stall = 1;
        cfg(1, 40, $urandom_range(1, 1023));
        step(600);
        cfg(0, 0, 10'h3FF);
        wait_idle(2000);
        for (int k = 0; k < 20; k++) begin
            cfg(0, 0, $urandom_range(0, 1023));
            trig();
            step($urandom_range(0, 6));
            trig();
            wait_idle(2000);
        end
        stall = 0;
        chk("overrun_random", bus.overrun_cnt_o, ovr_m);

        cfg(0, 0, 0);
        trig();
        step(5);
        chk("mask0_rd_v", bus.rd_v_o, 0);
        chk("mask0_overrun", bus.overrun_cnt_o, ovr_m);

        cfg(0, 0, 10'h001);
        begin
            int g = 0;
            while (seq_m != (1 << SW) - 1 && g < 400) begin trig(); wait_idle(50); g++; end
        end
        trig();
        wait_idle(50);
        chk("seq_wrap", last_seq, 0);

        cfg(0, 0, 10'h3FF);
        hold = 1;
        trig();
        begin
            int n = 0;
            while (!bus.rec_v_o && n < 50) begin step(); n++; end
            chk("push_in_budget", n < 50, 1);
        end
        reset = 1;
        step();
        chk_zero_outputs("midreset");
        reset = 0;
        hold = 0;
        step();
        trig();
        step(5);
        chk("post_reset_rd_v", bus.rd_v_o, 0);
        chk("post_reset_busy", bus.busy_o, 0);
        chk("post_reset_overrun", bus.overrun_cnt_o, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ktms_perfmon_sched.md
Name: ktms_perfmon_sched

Overview:
- Snapshot scheduler for the AFU performance-monitor counter bank: periodically, or on a software trigger, walks the enabled counter indices and reads each one through the perfmon valid/ready read port.
- Emits one tagged record per counter on an output stream consumed by the trace/DMA logger.
- Sits between the perfmon counter mux and the logger; the only master of the perfmon read port when enabled.

Parameters:
- ways, 10, number of counter indices (8 accumulators + 2 per stall counter).
- idx_width, $clog2(ways), width of counter index.
- seq_width, 16, width of snapshot sequence number.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_cfg_v  in  1  config load strobe.
- i_cfg_en  in  1  periodic enable, loaded on i_cfg_v.
- i_cfg_interval  in  32  period in cycles, loaded on i_cfg_v; 0 = periodic timer halted.
- i_cfg_mask  in  ways  per-index enable, loaded on i_cfg_v; bit 0 = index 0.
- i_trig  in  1  single-cycle manual snapshot request.
- o_rd_v  out  1  counter read request valid.
- i_rd_r  in  1  counter read request ready.
- o_rd_idx  out  idx_width  counter index requested.
- i_rsp_v  in  1  read data valid.
- o_rsp_r  out  1  read data ready.
- i_rsp_d  in  64  counter value.
- o_rec_v  out  1  record valid.
- i_rec_r  in  1  record ready.
- o_rec_idx  out  idx_width  counter index of record.
- o_rec_seq  out  seq_width  snapshot sequence number.
- o_rec_last  out  1  last record of the snapshot.
- o_rec_d  out  64  counter value.
- o_busy  out  1  snapshot in progress.
- o_overrun_cnt  out  32  saturating count of dropped snapshot requests.

Behaviour:
- Reset: all outputs 0; state IDLE; en=0, interval=0, mask=0, timer=0, seq=0, overrun=0.
- Config:
  - i_cfg_v latches en/interval/mask and loads timer=interval.
  - Mask in use is captured at snapshot start; a config load mid-snapshot does not alter the walk in progress.
- Timer:
  - While en=1 and interval!=0, timer decrements by 1 each cycle.
  - When timer==1, the tick pulses and the timer reloads to interval, giving a tick every interval cycles.
  - The first tick occurs interval cycles after the i_cfg_v cycle.
  - interval=1 ticks every cycle.
- Start request: tick OR i_trig.
  - Request while IDLE and captured mask!=0: seq<=seq+1 (wraps modulo 2^seq_width), snap_mask<=mask, go to ISSUE next cycle with o_rd_idx = lowest set bit.
  - Request while IDLE with mask==0: ignored; no seq change, no overrun.
  - Request while not IDLE: dropped, overrun increments, saturating at 0xFFFFFFFF.
  - Simultaneous tick and i_trig count as one request.
- FSM:
  - ISSUE: o_rd_v=1, o_rd_idx stable until i_rd_r; on handshake go to RESP.
  - RESP: o_rsp_r=1; on i_rsp_v capture i_rsp_d, idx, seq, last=(no higher set bit in snap_mask); go to PUSH.
  - PUSH: o_rec_v=1, record fields stable until i_rec_r. On handshake:
    - if last, go to IDLE;
    - else go to ISSUE with the next higher set bit.
  - Exactly one read outstanding; o_rsp_r=0 outside RESP.
- Idle-to-busy timing:
  - Minimum 3 cycles per record with zero-wait handshakes.
  - o_rd_v rises the cycle after the start request.
- o_busy = (state != IDLE).
- Clearing en mid-snapshot: the walk completes; only future ticks stop. i_trig still works with en=0.
- Reset mid-snapshot: abandon immediately; o_rd_v, o_rsp_r and o_rec_v drop in the cycle after reset is sampled.
- No combinational path from any input to o_rd_v or o_rec_v. o_rsp_r depends on state only.

Test Plan:
- Cfg en=1, interval=100, mask=0x3FF, zero-wait responder and sink:
  - records idx 0..9, seq=1, last only on idx 9;
  - second snapshot seq=2 begins 100 cycles after the first;
  - overrun=0.
- mask=0x0A5, i_trig pulse, en=0 -> exactly 4 records: idx 0, 2, 5, 7; last on idx 7; o_busy drops the cycle after the final i_rec_r.
- interval=10, mask=0x3FF, i_rec_r held low 50 cycles -> o_rec_d/idx stay stable; overrun increments by 5 per blocked window; no second snapshot overlaps.
- i_rd_r and i_rsp_v randomly stalled (0–7 cycles) -> o_rd_idx stable while o_rd_v && !i_rd_r; o_rec_d equals responder value per index; never more than one read outstanding.
- mask=0, i_trig -> no o_rd_v, seq unchanged, overrun=0.
- seq=0xFFFF, then trigger -> records carry seq=0x0000.
- Assert reset while in PUSH -> next cycle all outputs 0; after reset, i_trig with no config (mask=0) does nothing.
